// File: rtl/arbitro_memoria_datos.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Port 0 is the CPU MEM stage, port 1 the loader/DMA path; one transaction every three cycles.
module arbitro_memoria_datos #(
    parameter int ANCHO_DIR      = 32,
    parameter int ANCHO_DATO     = 32,
    parameter int PRIORIDAD_FIJA = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  escribir0,
    input  logic [ANCHO_DIR-1:0]  direccion0,
    input  logic [ANCHO_DATO-1:0] dato_escribir0,
    output logic                  ack0,
    output logic [ANCHO_DATO-1:0] dato_leer0,
    input  logic                  req1,
    input  logic                  escribir1,
    input  logic [ANCHO_DIR-1:0]  direccion1,
    input  logic [ANCHO_DATO-1:0] dato_escribir1,
    output logic                  ack1,
    output logic [ANCHO_DATO-1:0] dato_leer1,
    output logic                  mem_escribir,
    output logic                  mem_leer,
    output logic [ANCHO_DIR-1:0]  mem_direccion,
    output logic [ANCHO_DATO-1:0] mem_dato_escribir,
    input  logic [ANCHO_DATO-1:0] mem_dato_leer,
    output logic                  ocupado,
    output logic [15:0]           contador_tx
);

    typedef enum logic [2:0] {
        INACTIVO,
        SERVIR0,
        SERVIR1,
        RESP0,
        RESP1
    } estado_t;

    estado_t               estado;
    logic                  ultimo;       // port served last: 1 after reset so port 0 wins the first tie
    logic                  op_escribir;
    logic [ANCHO_DIR-1:0]  op_dir;
    logic [ANCHO_DATO-1:0] op_dato;
    logic                  conceder0;
    logic                  sirviendo;

    assign conceder0 = req0 && (!req1 || (PRIORIDAD_FIJA != 0) || ultimo);
    assign sirviendo = (estado == SERVIR0) || (estado == SERVIR1);
    assign ocupado   = (estado != INACTIVO);

    // NOTE: every output of this block must be given a default before the branches,
    // otherwise a missing path holds its old value and synthesis infers a latch.
    always_comb begin
        mem_escribir      = 1'b0;
        mem_leer          = 1'b0;
        mem_direccion     = '0;
        mem_dato_escribir = '0;
        if (sirviendo) begin
            mem_direccion = op_dir;
            if (op_escribir) begin
                mem_escribir      = 1'b1;
                mem_dato_escribir = op_dato;
            end else begin
                mem_leer = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado      <= INACTIVO;
            ultimo      <= 1'b1;
            op_escribir <= 1'b0;
            op_dir      <= '0;
            op_dato     <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            dato_leer0  <= '0;
            dato_leer1  <= '0;
            contador_tx <= '0;
        end else begin
            case (estado)
                INACTIVO: begin
                    if (conceder0) begin
                        estado      <= SERVIR0;
                        op_escribir <= escribir0;
                        op_dir      <= direccion0;
                        op_dato     <= dato_escribir0;
                    end else if (req1) begin
                        estado      <= SERVIR1;
                        op_escribir <= escribir1;
                        op_dir      <= direccion1;
                        op_dato     <= dato_escribir1;
                    end
                end
                SERVIR0: begin
                    estado      <= RESP0;
                    ack0        <= 1'b1;
                    ultimo      <= 1'b0;
                    contador_tx <= contador_tx + 16'd1;
                    if (!op_escribir) begin
                        dato_leer0 <= mem_dato_leer;
                    end
                end
                SERVIR1: begin
                    estado      <= RESP1;
                    ack1        <= 1'b1;
                    ultimo      <= 1'b1;
                    contador_tx <= contador_tx + 16'd1;
                    if (!op_escribir) begin
                        dato_leer1 <= mem_dato_leer;
                    end
                end
                RESP0: begin
                    ack0   <= 1'b0;
                    estado <= INACTIVO;
                end
                RESP1: begin
                    ack1   <= 1'b0;
                    estado <= INACTIVO;
                end
                default: estado <= INACTIVO;
            endcase
        end
    end

endmodule

// File: doc/arbitro_memoria_datos.md
Name: arbitro_memoria_datos

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory (256 words, word index = direccion[7:0], write on clock edge, combinational read gated by mem_leer).
- Port 0 is the CPU MEM stage; port 1 is the loader/DMA path.
- Grants one requester at a time, drives the memory control/address/data lines from a latched request, captures read data and returns a one-cycle ack.

Parameters:
- ANCHO_DIR, 32, address width passed to the memory.
- ANCHO_DATO, 32, data width.
- PRIORIDAD_FIJA, 0, 0 = round-robin between ports; 1 = port 0 always wins ties.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  port 0 request, held until ack0.
- escribir0  input  1  port 0 operation: 1 = write, 0 = read.
- direccion0  input  ANCHO_DIR  port 0 address.
- dato_escribir0  input  ANCHO_DATO  port 0 write data.
- ack0  output  1  port 0 completion pulse.
- dato_leer0  output  ANCHO_DATO  port 0 registered read data.
- req1, escribir1, direccion1, dato_escribir1, ack1, dato_leer1: same as port 0, for port 1.
- mem_escribir  output  1  to memory write enable.
- mem_leer  output  1  to memory read enable.
- mem_direccion  output  ANCHO_DIR  to memory address.
- mem_dato_escribir  output  ANCHO_DATO  to memory write data.
- mem_dato_leer  input  ANCHO_DATO  from memory read data (combinational).
- ocupado  output  1  high in any state other than INACTIVO.
- contador_tx  output  16  count of completed transactions.

Behaviour:
- States: INACTIVO, SERVIR0, SERVIR1, RESP0, RESP1.
- Reset: state INACTIVO, ack0/ack1 = 0, dato_leer0/1 = 0, contador_tx = 0, last-served register = 1 (port 0 wins the first tie).
- Reset: the latched op/address/data registers are cleared to 0.
- Memory outputs are decoded from the state register. Outside SERVIRx: mem_escribir = mem_leer = 0, mem_direccion = 0, mem_dato_escribir = 0.
- INACTIVO, at a rising edge:
  - Only req0 high: go to SERVIR0.
  - Only req1 high: go to SERVIR1.
  - Both high, PRIORIDAD_FIJA = 1: port 0 is granted.
  - Both high, PRIORIDAD_FIJA = 0: the port not served last is granted.
  - On any grant, latch that port's escribirX, direccionX and dato_escribirX.
- SERVIRx, for one cycle:
  - mem_direccion = latched address.
  - Latched write: mem_escribir = 1, mem_leer = 0, mem_dato_escribir = latched data.
  - Latched read: mem_leer = 1, mem_escribir = 0.
  - mem_escribir and mem_leer are never both 1.
- Leaving SERVIRx at the next edge:
  - The memory commits the write.
  - For a read, mem_dato_leer is registered into dato_leerX.
  - Go to RESPx; ackX = 1 (registered); update last-served = x; contador_tx += 1, wrapping from 0xFFFF to 0.
- RESPx: ackX is high for exactly one cycle, then the block returns to INACTIVO with ackX = 0.
  - Requests are not sampled in RESPx.
- Latency: from the edge that samples req to ack high is 2 edges. Throughput is one transaction per 3 cycles.
- Requester rule: deassert reqX in the cycle after ackX. A req still high at the next INACTIVO edge is a new transaction.
- Write transactions leave dato_leerX unchanged. dato_leerX holds its value until that port's next read.
- A losing requester keeps req high and is served at the next INACTIVO edge. Round-robin guarantees it is served before the winner is served again.
- Request inputs that change while in SERVIR or RESP do not affect the in-flight transaction, because it uses the latched values.
- Reset asserted mid-operation:
  - Memory enables drop immediately (combinational decode of the cleared state).
  - A write in SERVIRx whose commit edge has not yet occurred is lost.
  - No ack is generated.
- ocupado = (state != INACTIVO).

Test Plan:
- Single write then read, port 0: write direccion0 = 0x05, dato = 0xDEADBEEF, then read 0x05.
  - Required: ack0 two edges after req sampled; mem_escribir is high for exactly one cycle.
  - Required: dato_leer0 = 0xDEADBEEF; contador_tx = 2.
- Simultaneous requests, PRIORIDAD_FIJA = 0: req0 and req1 held high continuously.
  - Required: grant order 0, 1, 0, 1; an ack every 3 cycles; the two acks are never high together.
- Simultaneous requests, PRIORIDAD_FIJA = 1: both held high.
  - Required: port 0 is served every time; port 1 is served only after req0 drops.
- Port 1 read of preloaded word 0x10 = 0x00000007 while port 0 writes 0x11 = 0x1.
  - Required: dato_leer1 = 0x00000007; dato_leer0 is unchanged at 0.
- Reset asserted during SERVIR0 (write 0x20 = 0xFFFFFFFF).
  - Required: mem_escribir drops in the same cycle; memory[0x20] is unchanged; ack0 stays 0.
  - Required: outputs return to reset values; ocupado = 0.
- Counter wrap: force 65536 transactions (or preload the count).
  - Required: contador_tx goes from 0xFFFF to 0x0000; mem_leer and mem_escribir are never both 1, checked throughout.
